// File: rtl/fusion_pkg.sv
// Shared types and helpers for the Bit Fusion multiply-accumulate unit.
// Brick products are 6-bit two's complement, wide enough for any 2x2 signedness combination.
package fusion_pkg;

   localparam int FUSION_W = 8;
   localparam int NBB      = (FUSION_W / 2) * (FUSION_W / 2);
   localparam int BB_W     = 6;

   typedef enum logic [2:0] {P2, P4, P8, P16, P32, P64} prec_t;

   function automatic int lane_w(input int m);
      return 2 << m;
   endfunction

   function automatic int lane_cnt(input int w, input int m);
      return w / lane_w(m);
   endfunction

endpackage

// File: rtl/bitbrick.sv
// 2x2-bit multiplier brick; emits all four signedness variants, indexed {x_signed, y_signed}.
module bitbrick
   import fusion_pkg::*;
(
   input  logic [1:0]           x,
   input  logic [1:0]           y,
   output logic [3:0][BB_W-1:0] p
);

   logic [BB_W-1:0] xu, xs, yu, ys;

   assign xu = {{(BB_W-2){1'b0}}, x};
   assign xs = {{(BB_W-2){x[1]}}, x};
   assign yu = {{(BB_W-2){1'b0}}, y};
   assign ys = {{(BB_W-2){y[1]}}, y};

   assign p[0] = xu * yu;
   assign p[1] = xu * ys;
   assign p[2] = xs * yu;
   assign p[3] = xs * ys;

endmodule

// File: rtl/fusion_lane_sum.sv
// Fuses brick products into lanes for every precision mode and selects the requested one.
// Only the top brick row/column of a lane is treated as signed; cross-lane bricks drop out.
module fusion_lane_sum
   import fusion_pkg::*;
#(
   parameter int W     = 8,
   parameter int ACC_W = 32,
   parameter int NMODE = $clog2(W),
   parameter int PW    = (NMODE > 1) ? $clog2(NMODE) : 1
) (
   input  logic [(W/2)*(W/2)-1:0][3:0][BB_W-1:0] prod,
   input  logic [PW-1:0]                         prec,
   input  logic                                  sa,
   input  logic                                  sb,
   output logic [ACC_W-1:0]                      lane_sum
);

   localparam int HB = W / 2;

   logic [ACC_W-1:0] mode_sum [NMODE];

   function automatic logic [ACC_W-1:0] sext(input logic [BB_W-1:0] v);
      return {{(ACC_W-BB_W){v[BB_W-1]}}, v};
   endfunction

   // Every mode is built from constants so each collapses to a fixed shift-add tree.
   always_comb begin
      for (int m = 0; m < NMODE; m++) begin
         mode_sum[m] = '0;
         for (int r = 0; r < HB; r++) begin
            for (int c = 0; c < HB; c++) begin
               if ((r >> m) == (c >> m)) begin
                  mode_sum[m] = mode_sum[m]
                     + (sext(prod[r*HB+c][{sa && ((r % (lane_w(m)/2)) == (lane_w(m)/2 - 1)),
                                          sb && ((c % (lane_w(m)/2)) == (lane_w(m)/2 - 1))}])
                        << (2*(r % (lane_w(m)/2)) + 2*(c % (lane_w(m)/2))));
               end
            end
         end
      end
      lane_sum = '0;
      if (int'(prec) < NMODE) begin
         lane_sum = mode_sum[prec];
      end
   end

endmodule

// File: rtl/fusion_unit.sv
// Pipelined Bit Fusion MAC: input reg, brick product reg, lane sum reg, accumulator/output reg.
// A single global enable stalls every stage while a result waits for the consumer.
module fusion_unit
   import fusion_pkg::*;
#(
   parameter int W     = 8,
   parameter int ACC_W = 32,
   parameter int NMODE = $clog2(W)
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        in_valid,
   output logic                                        in_ready,
   input  logic [W-1:0]                                a,
   input  logic [W-1:0]                                b,
   input  logic                                        sa,
   input  logic                                        sb,
   input  logic [((NMODE > 1) ? $clog2(NMODE) : 1)-1:0] prec,
   input  logic                                        acc_clr,
   input  logic                                        acc_last,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic [ACC_W-1:0]                            out_data,
   output logic                                        out_ovf,
   output logic                                        err
);

   localparam int PW = (NMODE > 1) ? $clog2(NMODE) : 1;
   localparam int HB = W / 2;
   localparam int NB = HB * HB;

   logic                         en;
   logic                         s1_valid, s1_sa, s1_sb, s1_clr, s1_last;
   logic [W-1:0]                 s1_a, s1_b;
   logic [PW-1:0]                s1_prec;
   logic [NB-1:0][3:0][BB_W-1:0] bb_prod, s2_prod;
   logic                         s2_valid, s2_sa, s2_sb, s2_clr, s2_last;
   logic [PW-1:0]                s2_prec;
   logic [ACC_W-1:0]             ls, s3_sum;
   logic                         s3_valid, s3_clr, s3_last;
   logic [ACC_W-1:0]             acc, acc_sum;
   logic                         ovf_sticky, add_ovf, sticky_nxt;

   assign en       = !(out_valid && !out_ready);
   assign in_ready = en;

   for (genvar r = 0; r < HB; r++) begin : g_row
      for (genvar c = 0; c < HB; c++) begin : g_col
         bitbrick u_bb (
            .x (s1_a[2*r +: 2]),
            .y (s1_b[2*c +: 2]),
            .p (bb_prod[r*HB+c])
         );
      end
   end

   fusion_lane_sum #(.W(W), .ACC_W(ACC_W), .NMODE(NMODE), .PW(PW)) u_lane_sum (
      .prod     (s2_prod),
      .prec     (s2_prec),
      .sa       (s2_sa),
      .sb       (s2_sb),
      .lane_sum (ls)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0; s1_a <= '0; s1_b <= '0; s1_sa <= 1'b0; s1_sb <= 1'b0;
         s1_prec  <= '0;   s1_clr <= 1'b0; s1_last <= 1'b0;
         s2_valid <= 1'b0; s2_prod <= '0; s2_sa <= 1'b0; s2_sb <= 1'b0;
         s2_prec  <= '0;   s2_clr <= 1'b0; s2_last <= 1'b0;
         s3_valid <= 1'b0; s3_sum <= '0; s3_clr <= 1'b0; s3_last <= 1'b0;
      end else if (en) begin
         s1_valid <= in_valid; s1_a <= a; s1_b <= b; s1_sa <= sa; s1_sb <= sb;
         s1_prec  <= prec;     s1_clr <= acc_clr; s1_last <= acc_last;
         s2_valid <= s1_valid; s2_prod <= bb_prod; s2_sa <= s1_sa; s2_sb <= s1_sb;
         s2_prec  <= s1_prec;  s2_clr <= s1_clr; s2_last <= s1_last;
         s3_valid <= s2_valid; s3_sum <= ls; s3_clr <= s2_clr; s3_last <= s2_last;
      end
   end

   // A clearing beat loads lane_sum directly, so it can never overflow.
   always_comb begin
      acc_sum    = (s3_clr ? '0 : acc) + s3_sum;
      add_ovf    = !s3_clr && (acc[ACC_W-1] == s3_sum[ACC_W-1])
                   && (acc_sum[ACC_W-1] != acc[ACC_W-1]);
      sticky_nxt = !s3_clr && (ovf_sticky || add_ovf);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc        <= '0;
         ovf_sticky <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_ovf    <= 1'b0;
         err        <= 1'b0;
      end else begin
         if (en) begin
            out_valid <= s3_valid && s3_last;
            if (s3_valid) begin
               acc        <= acc_sum;
               ovf_sticky <= sticky_nxt;
               if (s3_last) begin
                  out_data <= acc_sum;
                  out_ovf  <= sticky_nxt;
               end
            end
         end
         if (in_valid && en && int'(prec) >= NMODE) begin
            err <= 1'b1;
         end
      end
   end

endmodule
